configreg_shift_sequencer: RTL and testbench
============================================

// Module: configreg_shift_sequencer
// PURPOSE
//  Sequences one full write/readback of the chip config shift register. Pulls CONFIG_REG_WIDTH bits
//  from a DATA_WIDTH word stream and shifts them out on ConfigIn under a divided ConfigClk.
//  Captures ConfigOut into readback words, then pulses ConfigLoad. Also issues a timed chip
//  reset on Reset_not. Sits between the AXI register file and the ConfigIn/ConfigClk/ConfigLoad/
//  ConfigOut/Reset_not/SuperpixSel pins.
// PARAMETERS
//  DATA_WIDTH        32    word width of the data and readback streams
//  CONFIG_REG_WIDTH  5164  bits per shift; NWORDS = ceil(CONFIG_REG_WIDTH/DATA_WIDTH)
//  CLK_DIVIDER       100   S_AXI_ACLK cycles per ConfigClk half-period (>=1)
// PORTS
//  S_AXI_ACLK     in   1   sole clock
//  S_AXI_ARESET   in   1   reset, synchronous, active-high
//  start          in   1   begin shift sequence (sampled in IDLE only)
//  abort          in   1   terminate current operation
//  chip_rst_req   in   1   request chip reset pulse (sampled in IDLE only)
//  superpix_sel   in   1   SuperpixSel value, latched on accepted start
//  word_in        in   DW  config word; bit 0 is shifted first
//  word_valid     in   1   word_in valid
//  word_ready     out  1   word consumed when word_valid && word_ready
//  rb_word        out  DW  readback word (unused upper bits of last word = 0)
//  rb_valid       out  1   one-cycle strobe, rb_word valid
//  busy           out  1   high in any state except IDLE
//  done           out  1   one-cycle strobe at completion of shift+load
//  SuperpixSel ConfigClk ConfigIn ConfigLoad Reset_not  out 1  chip pins
//  ConfigOut      in   1   chip serial out
// BEHAVIOUR
//  Interface: one clock; reset is synchronous and active-high.
//  Reset values: ConfigClk=0 ConfigIn=0 ConfigLoad=0 Reset_not=1 SuperpixSel=0 busy=0 word_ready=0
//   rb_valid=0 rb_word=0 done=0; FSM in IDLE; all counters 0.
//  Reset mid-operation: all of the above next edge; no ConfigLoad is issued.
//  FSM: IDLE, CHIPRST, FETCH, SHIFT_LO, SHIFT_HI, LOAD, DONE.
//  IDLE: start -> FETCH, latch superpix_sel; else chip_rst_req -> CHIPRST; start wins if both.
//  CHIPRST: Reset_not=0 for 2*CLK_DIVIDER cycles -> IDLE.
//  FETCH: word_ready=1, ConfigClk held 0; handshake -> SHIFT_LO with bit 0.
//   No valid word: wait indefinitely (stall, no error).
//  SHIFT_LO: ConfigClk=0, ConfigIn=current bit, CLK_DIVIDER cycles; ConfigOut sampled on last cycle
//   into readback bit of same index -> SHIFT_HI.
//  SHIFT_HI: ConfigClk=1, CLK_DIVIDER cycles; ConfigIn stable.
//   Then: more bits in word -> SHIFT_LO; word end -> rb_valid strobe, then FETCH if words remain,
//   else LOAD. Last word holds CONFIG_REG_WIDTH-(NWORDS-1)*DATA_WIDTH bits; higher bits ignored.
//  Bit counter wraps at word end or total-bit end, whichever first; total counter never exceeds width.
//  LOAD: ConfigClk=0, ConfigLoad=1 for 2*CLK_DIVIDER cycles -> DONE.
//  DONE: done=1 one cycle -> IDLE.
//  abort: any non-IDLE state -> IDLE next edge; ConfigClk/ConfigIn/ConfigLoad=0, Reset_not=1,
//   no done, no rb_valid; SuperpixSel keeps latched value.
//  start/chip_rst_req outside IDLE: ignored.
//  rb_valid has no backpressure; consumer must accept on strobe.
// CONFIGURATION
//  CONFIGREG_READBACK_EN defined: ConfigOut capture and rb_word/rb_valid as above.
//  Undefined: no capture logic; rb_word tied 0, rb_valid tied 0; shift/load timing unchanged.
// TESTING  (DW=32, CONFIG_REG_WIDTH=40, CLK_DIVIDER=2 unless noted)
//  Words 0xA5A5A5A5, 0x0000003C, start -> ConfigIn follows LSB-first 40 bits, 4 clk/bit; ConfigLoad
//   high 4 cycles after bit 39; done once; 2 word handshakes total.
//  ConfigOut looped to ConfigIn via 40-bit model preloaded 0x12_3456789A -> rb_word 0x3456789A
//   then 0x00000012.
//  word_valid withheld 20 cycles before word 1 -> ConfigClk stays 0 for the stall; bit stream intact.
//  abort during bit 10 -> IDLE next cycle, ConfigLoad never asserted, done=0, busy=0.
//  chip_rst_req in IDLE -> Reset_not=0 exactly 4 cycles; start during CHIPRST ignored.
//  S_AXI_ARESET during LOAD -> ConfigLoad=0 next edge, all outputs at reset values.
//  Build without CONFIGREG_READBACK_EN -> rb_valid never asserts; pin timing identical.

Source files
------------

// File: rtl/configreg_shift_sequencer_if.sv
// Word stream into the sequencer and readback stream out of it.
// master: register-file side (drives words, receives readback).
// slave:  sequencer side.
interface configreg_shift_sequencer_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] word_in;
  logic                  word_valid;
  logic                  word_ready;
  logic [DATA_WIDTH-1:0] rb_word;
  logic                  rb_valid;

  modport master (
    output word_in,
    output word_valid,
    input  word_ready,
    input  rb_word,
    input  rb_valid
  );

  modport slave (
    input  word_in,
    input  word_valid,
    output word_ready,
    output rb_word,
    output rb_valid
  );
endinterface

// File: rtl/configreg_shift_sequencer.sv
// Config shift-register sequencer: fetches words, shifts CONFIG_REG_WIDTH bits out LSB-first on
// ConfigIn under a divided ConfigClk, pulses ConfigLoad, and issues timed chip resets.
// Optional readback capture of ConfigOut is enabled by defining CONFIGREG_READBACK_EN.
module configreg_shift_sequencer #(
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned CONFIG_REG_WIDTH = 5164,
  parameter int unsigned CLK_DIVIDER      = 100
) (
  input  logic                              S_AXI_ACLK,
  input  logic                              S_AXI_ARESET,
  input  logic                              start,
  input  logic                              abort,
  input  logic                              chip_rst_req,
  input  logic                              superpix_sel,
  configreg_shift_sequencer_if.slave        bus,
  output logic                              busy,
  output logic                              done,
  output logic                              SuperpixSel,
  output logic                              ConfigClk,
  output logic                              ConfigIn,
  output logic                              ConfigLoad,
  output logic                              Reset_not,
  input  logic                              ConfigOut
);

  localparam int unsigned CntW = (2 * CLK_DIVIDER > 1) ? $clog2(2 * CLK_DIVIDER) : 1;
  localparam int unsigned BitW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int unsigned TotW = (CONFIG_REG_WIDTH > 1) ? $clog2(CONFIG_REG_WIDTH) : 1;

  localparam logic [CntW-1:0] HalfLast = CntW'(CLK_DIVIDER - 1);
  localparam logic [CntW-1:0] LongLast = CntW'(2 * CLK_DIVIDER - 1);
  localparam logic [BitW-1:0] BitLast  = BitW'(DATA_WIDTH - 1);
  localparam logic [TotW-1:0] TotLast  = TotW'(CONFIG_REG_WIDTH - 1);

  typedef enum logic [2:0] {
    StIdle, StChipRst, StFetch, StShiftLo, StShiftHi, StLoad, StDone
  } state_e;

  state_e                state_q;
  logic [CntW-1:0]       cnt_q;
  logic [BitW-1:0]       bit_q;
  logic [TotW-1:0]       tot_q;
  // Remaining bits of the current word; bit 0 is the next bit to go out.
  logic [DATA_WIDTH-2:0] word_q;
  logic                  config_clk_q, config_in_q, config_load_q, reset_n_q, superpix_q;
  logic                  busy_q, done_q, word_ready_q;

  logic half_end, long_end, last_bit, handshake, abort_now;

  assign half_end  = (cnt_q == HalfLast);
  assign long_end  = (cnt_q == LongLast);
  // Word ends on its own last bit, or early on the final bit of the whole register.
  assign last_bit  = (bit_q == BitLast) || (tot_q == TotLast);
  assign handshake = bus.word_valid && word_ready_q;
  assign abort_now = abort && (state_q != StIdle);

  // Sequencer FSM with registered pin/status outputs.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      bit_q         <= '0;
      tot_q         <= '0;
      word_q        <= '0;
      config_clk_q  <= 1'b0;
      config_in_q   <= 1'b0;
      config_load_q <= 1'b0;
      reset_n_q     <= 1'b1;
      superpix_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      word_ready_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort_now) begin
        state_q       <= StIdle;
        cnt_q         <= '0;
        bit_q         <= '0;
        tot_q         <= '0;
        config_clk_q  <= 1'b0;
        config_in_q   <= 1'b0;
        config_load_q <= 1'b0;
        reset_n_q     <= 1'b1;
        busy_q        <= 1'b0;
        word_ready_q  <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            cnt_q <= '0;
            if (start) begin
              state_q      <= StFetch;
              superpix_q   <= superpix_sel;
              busy_q       <= 1'b1;
              word_ready_q <= 1'b1;
              bit_q        <= '0;
              tot_q        <= '0;
            end else if (chip_rst_req) begin
              state_q   <= StChipRst;
              reset_n_q <= 1'b0;
              busy_q    <= 1'b1;
            end
          end
          StChipRst: begin
            if (long_end) begin
              state_q   <= StIdle;
              reset_n_q <= 1'b1;
              busy_q    <= 1'b0;
              cnt_q     <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          StFetch: begin
            if (handshake) begin
              state_q      <= StShiftLo;
              word_ready_q <= 1'b0;
              config_in_q  <= bus.word_in[0];
              word_q       <= bus.word_in[DATA_WIDTH-1:1];
              cnt_q        <= '0;
            end
          end
          StShiftLo: begin
            if (half_end) begin
              state_q      <= StShiftHi;
              config_clk_q <= 1'b1;
              cnt_q        <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          StShiftHi: begin
            if (half_end) begin
              config_clk_q <= 1'b0;
              cnt_q        <= '0;
              if (!last_bit) begin
                state_q     <= StShiftLo;
                bit_q       <= bit_q + 1'b1;
                tot_q       <= tot_q + 1'b1;
                config_in_q <= word_q[0];
                word_q      <= word_q >> 1;
              end else begin
                bit_q <= '0;
                if (tot_q == TotLast) begin
                  state_q       <= StLoad;
                  config_in_q   <= 1'b0;
                  config_load_q <= 1'b1;
                end else begin
                  state_q      <= StFetch;
                  tot_q        <= tot_q + 1'b1;
                  word_ready_q <= 1'b1;
                end
              end
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          StLoad: begin
            if (long_end) begin
              state_q       <= StDone;
              config_load_q <= 1'b0;
              done_q        <= 1'b1;
              cnt_q         <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          StDone: begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            tot_q   <= '0;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign ConfigClk      = config_clk_q;
  assign ConfigIn       = config_in_q;
  assign ConfigLoad     = config_load_q;
  assign Reset_not      = reset_n_q;
  assign SuperpixSel    = superpix_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign bus.word_ready = word_ready_q;

`ifdef CONFIGREG_READBACK_EN
  logic [DATA_WIDTH-1:0] rb_acc_q, rb_word_q;
  logic                  rb_valid_q;

  // Capture ConfigOut at the end of each low phase; publish the word when it completes.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      rb_acc_q   <= '0;
      rb_word_q  <= '0;
      rb_valid_q <= 1'b0;
    end else begin
      rb_valid_q <= 1'b0;
      if (!abort_now) begin
        // Clearing per word keeps unused upper bits of a short last word at 0.
        if (state_q == StFetch && handshake) begin
          rb_acc_q <= '0;
        end
        if (state_q == StShiftLo && half_end) begin
          rb_acc_q[bit_q] <= ConfigOut;
        end
        if (state_q == StShiftHi && half_end && last_bit) begin
          rb_word_q  <= rb_acc_q;
          rb_valid_q <= 1'b1;
        end
      end
    end
  end

  assign bus.rb_word  = rb_word_q;
  assign bus.rb_valid = rb_valid_q;
`else
  logic unused_config_out;
  assign unused_config_out = ConfigOut;
  assign bus.rb_word       = '0;
  assign bus.rb_valid      = 1'b0;
`endif

endmodule

// File: tb/tb_configreg_shift_sequencer.sv
// Bench for configreg_shift_sequencer (DW=32, CONFIG_REG_WIDTH=40, CLK_DIVIDER=2).
// A 40-bit chip shift-register model loops ConfigIn back to ConfigOut.
module tb_configreg_shift_sequencer;
  localparam int unsigned DW  = 32;
  localparam int unsigned CRW = 40;
  localparam int unsigned CD  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, abort = 1'b0, chip_rst_req = 1'b0, superpix_sel = 1'b0;
  logic busy, done, SuperpixSel, ConfigClk, ConfigIn, ConfigLoad, Reset_not, ConfigOut;

  configreg_shift_sequencer_if #(.DATA_WIDTH(DW)) bus ();

  configreg_shift_sequencer #(
    .DATA_WIDTH(DW),
    .CONFIG_REG_WIDTH(CRW),
    .CLK_DIVIDER(CD)
  ) dut (
    .S_AXI_ACLK(clk),
    .S_AXI_ARESET(rst),
    .start(start),
    .abort(abort),
    .chip_rst_req(chip_rst_req),
    .superpix_sel(superpix_sel),
    .bus(bus),
    .busy(busy),
    .done(done),
    .SuperpixSel(SuperpixSel),
    .ConfigClk(ConfigClk),
    .ConfigIn(ConfigIn),
    .ConfigLoad(ConfigLoad),
    .Reset_not(Reset_not),
    .ConfigOut(ConfigOut)
  );

  always #5 clk = ~clk;

  // Chip shift-register model: shifts ConfigIn in at the MSB on each ConfigClk rise.
  logic [CRW-1:0] sr, sr_init = '0;
  logic sr_load = 1'b1;
  logic cclk_d = 1'b0;
  always @(posedge clk) begin
    if (sr_load) sr <= sr_init;
    else if (ConfigClk && !cclk_d) sr <= {ConfigIn, sr[CRW-1:1]};
    cclk_d <= ConfigClk;
  end
  assign ConfigOut = sr[0];

  typedef struct {
    logic [31:0] w0;
    logic [31:0] w1;
    logic [39:0] preload;
    int          stall;
    logic        sp;
    logic [39:0] exp_stream;
    logic [31:0] exp_rb0;
    logic [31:0] exp_rb1;
  } vec_t;

  int total = 0, bad = 0;
  int cyc = 0;
  // Monitor state, updated by tick().
  logic [63:0] stream;
  int nbits, last_rise, load_cnt, load_first, done_cnt, rb_n, hs_cnt;
  logic period_ok, stable_ok, stall_ok, hold_bit, clk_prev, hs_pend;
  logic [31:0] rb_got [4];
  // Word feeder state.
  logic [31:0] feed_words [2];
  logic feed_en = 1'b0;
  int feed_idx, stall_ctr, cur_stall;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic reset_mon();
    stream = '0; nbits = 0; last_rise = 0; load_cnt = 0; load_first = 0; done_cnt = 0;
    rb_n = 0; hs_cnt = 0; period_ok = 1'b1; stable_ok = 1'b1; stall_ok = 1'b1;
    hold_bit = 1'b0; clk_prev = 1'b0; hs_pend = 1'b0; feed_idx = 0; stall_ctr = 0;
    for (int i = 0; i < 4; i++) rb_got[i] = '0;
  endtask

  // One clock: sample outputs on the falling edge, then drive the word stream.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (hs_pend) begin
      feed_idx++;
      hs_cnt++;
    end
    if (ConfigClk && !clk_prev) begin
      if (nbits < 64) stream[nbits] = ConfigIn;
      if (nbits != 0 && nbits != DW && (cyc - last_rise) != 2 * CD) period_ok = 1'b0;
      last_rise = cyc;
      hold_bit  = ConfigIn;
      nbits++;
    end else if (ConfigClk && clk_prev && ConfigIn !== hold_bit) begin
      stable_ok = 1'b0;
    end
    if (bus.word_ready && ConfigClk) stall_ok = 1'b0;
    if (ConfigLoad) begin
      if (load_cnt == 0) load_first = cyc;
      load_cnt++;
    end
    if (done) done_cnt++;
    if (bus.rb_valid) begin
      if (rb_n < 4) rb_got[rb_n] = bus.rb_word;
      rb_n++;
    end
    clk_prev = ConfigClk;
    if (feed_idx == 1 && bus.word_ready) stall_ctr++;
    if (feed_en && feed_idx < 2 && !(feed_idx == 1 && stall_ctr <= cur_stall)) begin
      bus.word_valid = 1'b1;
      bus.word_in    = feed_words[feed_idx];
    end else begin
      bus.word_valid = 1'b0;
      bus.word_in    = '0;
    end
    hs_pend = bus.word_valid && bus.word_ready;
  endtask

  task automatic chk_reset_state(input string name);
    chk(name, {ConfigClk, ConfigIn, ConfigLoad, Reset_not, SuperpixSel, busy, bus.word_ready,
               bus.rb_valid, done}, 9'b000100000);
    chk({name, "_rb_word"}, bus.rb_word, 32'h0);
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    logic saw_busy;
    reset_mon();
    sr_init = v.preload;
    sr_load = 1'b1;
    tick();
    sr_load = 1'b0;
    feed_words[0] = v.w0;
    feed_words[1] = v.w1;
    cur_stall = v.stall;
    feed_en = 1'b1;
    superpix_sel = v.sp;
    start = 1'b1;
    tick();
    start = 1'b0;
    superpix_sel = ~v.sp;
    saw_busy = 1'b0;
    n = 0;
    while (n < 1000) begin
      tick();
      if (busy) saw_busy = 1'b1;
      else if (saw_busy) break;
      n++;
    end
    feed_en = 1'b0;
    chk("seq_timeout", 64'(n >= 1000), 0);
    chk("bit_count", nbits, 40);
    chk("bit_stream", stream[39:0], v.exp_stream);
    chk("chip_sr", sr, v.exp_stream);
    chk("handshakes", hs_cnt, 2);
    chk("done_pulses", done_cnt, 1);
    chk("load_cycles", load_cnt, 2 * CD);
    chk("load_delay", load_first - last_rise, CD);
    chk("bit_period", period_ok, 1);
    chk("bit_stable", stable_ok, 1);
    chk("fetch_clk_low", stall_ok, 1);
    chk("superpix", SuperpixSel, v.sp);
`ifdef CONFIGREG_READBACK_EN
    chk("rb_count", rb_n, 2);
    chk("rb_word0", rb_got[0], v.exp_rb0);
    chk("rb_word1", rb_got[1], v.exp_rb1);
`else
    chk("rb_count", rb_n, 0);
`endif
  endtask

  vec_t vecs [3];

  initial begin
    int n, rn_low, wr_seen, l0;
    vecs[0] = '{w0: 32'hA5A5A5A5, w1: 32'h0000003C, preload: 40'h12_3456789A, stall: 0,
                sp: 1'b1, exp_stream: 40'h3C_A5A5A5A5, exp_rb0: 32'h3456789A,
                exp_rb1: 32'h00000012};
    vecs[1] = '{w0: 32'hFFFFFFFF, w1: 32'hFFFFFF81, preload: 40'hFF_00000000, stall: 20,
                sp: 1'b0, exp_stream: 40'h81_FFFFFFFF, exp_rb0: 32'h00000000,
                exp_rb1: 32'h000000FF};
    vecs[2] = '{w0: 32'h00000001, w1: 32'hABCDEF00, preload: 40'h00_80000001, stall: 5,
                sp: 1'b1, exp_stream: 40'h00_00000001, exp_rb0: 32'h80000001,
                exp_rb1: 32'h00000000};
    bus.word_valid = 1'b0;
    bus.word_in    = '0;
    reset_mon();

    // Reset values, both while held and just after release.
    repeat (3) tick();
    chk_reset_state("reset_state");
    rst = 1'b0;
    sr_load = 1'b0;
    tick();
    chk_reset_state("idle_state");

    for (int i = 0; i < 3; i++) run_vec(vecs[i]);

    // Abort during bit 10: back to idle at once, no load, no done, SuperpixSel kept.
    reset_mon();
    feed_words[0] = 32'hFFFFFFFF;
    feed_words[1] = 32'hFFFFFFFF;
    cur_stall = 0;
    feed_en = 1'b1;
    superpix_sel = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    superpix_sel = 1'b0;
    n = 0;
    while (nbits < 11 && n < 500) begin
      tick();
      n++;
    end
    chk("abort_reach", 64'(n >= 500), 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    feed_en = 1'b0;
    chk("abort_idle", {busy, ConfigClk, ConfigIn, ConfigLoad, bus.word_ready, Reset_not},
        6'b000001);
    repeat (40) tick();
    chk("abort_no_load", load_cnt, 0);
    chk("abort_no_done", done_cnt, 0);
    chk("abort_no_rb", rb_n, 0);
    chk("abort_sp_kept", SuperpixSel, 1);
    chk("abort_busy", busy, 0);

    // Chip reset: Reset_not low for 2*CD cycles; start during it is ignored.
    reset_mon();
    rn_low = 0;
    wr_seen = 0;
    chip_rst_req = 1'b1;
    tick();
    if (!Reset_not) rn_low++;
    chip_rst_req = 1'b0;
    start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 1) start = 1'b0;
      if (!Reset_not) rn_low++;
      if (bus.word_ready) wr_seen++;
    end
    chk("chiprst_low_cycles", rn_low, 2 * CD);
    chk("chiprst_start_ignored", wr_seen, 0);
    chk("chiprst_busy_end", busy, 0);

    // Reset asserted while ConfigLoad is high.
    reset_mon();
    sr_init = '0;
    sr_load = 1'b1;
    tick();
    sr_load = 1'b0;
    feed_words[0] = 32'h13572468;
    feed_words[1] = 32'h0000005A;
    cur_stall = 0;
    feed_en = 1'b1;
    superpix_sel = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!ConfigLoad && n < 1000) begin
      tick();
      n++;
    end
    chk("load_reach", 64'(n >= 1000), 0);
    feed_en = 1'b0;
    rst = 1'b1;
    tick();
    chk_reset_state("reset_in_load");
    l0 = load_cnt;
    rst = 1'b0;
    repeat (20) tick();
    chk("rst_no_done", done_cnt, 0);
    chk("rst_no_more_load", load_cnt, l0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
